// File: rtl/mem_line_sequencer_if.sv
// Arbiter-side line request and external 32-bit beat port of the line sequencer.
// The sequencer connects through the slave modport; the arbiter/memory side uses master.
interface mem_line_sequencer_if;
  logic         is_mem_req;
  logic         mem_we;
  logic [19:0]  mem_addr;
  logic [127:0] dcache_to_mem_data_out;
  logic         reset_mem_req;
  logic [127:0] data_from_mem;
  logic         mem_ready;
  logic         mem_error;
  logic         busy;
  logic         ext_req;
  logic         ext_we;
  logic [19:0]  ext_addr;
  logic [31:0]  ext_wdata;
  logic         ext_ack;
  logic [31:0]  ext_rdata;

  modport slave (
    input  is_mem_req, mem_we, mem_addr, dcache_to_mem_data_out, reset_mem_req,
    input  ext_ack, ext_rdata,
    output data_from_mem, mem_ready, mem_error, busy,
    output ext_req, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output is_mem_req, mem_we, mem_addr, dcache_to_mem_data_out, reset_mem_req,
    output ext_ack, ext_rdata,
    input  data_from_mem, mem_ready, mem_error, busy,
    input  ext_req, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/mem_line_sequencer.sv
// Splits one 128-bit line request into four 32-bit req/ack beats, with per-beat
// timeout and abort; read lines are assembled and returned with a mem_ready pulse.
module mem_line_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 reset,
  mem_line_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t       state;
  logic [15:0]  line_q;
  logic         we_q;
  logic [127:0] wline_q;
  logic [95:0]  shadow_q;
  logic [1:0]   beat_q;
  logic [7:0]   tmo_q;
  logic         abort_q;

  logic [127:0] data_q;
  logic         ready_q;
  logic         error_q;
  logic         busy_q;
  logic         ext_req_q;
  logic         ext_we_q;
  logic [19:0]  ext_addr_q;
  logic [31:0]  ext_wdata_q;

  logic         ack_hit;
  logic         tmo_hit;
  logic         abort_now;
  logic         last_beat;
  logic [7:0]   tmo_next;

  function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] idx);
    return line[32*idx +: 32];
  endfunction

  function automatic logic [19:0] beat_addr(input logic [15:0] line, input logic [1:0] idx);
    return {line, idx, 2'b00};
  endfunction

  // Only words 0..2 are parked here; word 3 goes straight from ext_rdata to the result.
  function automatic logic [95:0] shadow_put(input logic [95:0] shadow, input logic [1:0] idx,
                                             input logic [31:0] word);
    logic [95:0] res;
    res = shadow;
    case (idx)
      2'd0:    res[31:0]  = word;
      2'd1:    res[63:32] = word;
      2'd2:    res[95:64] = word;
      default: res        = shadow;
    endcase
    return res;
  endfunction

  assign ack_hit   = (state == BEAT) && ext_req_q && bus.ext_ack;
  assign tmo_next  = tmo_q + 8'd1;
  // An ack in the limit cycle takes precedence over the timeout.
  assign tmo_hit   = (state == BEAT) && !bus.ext_ack && (tmo_next == TMO_LIMIT);
  assign abort_now = abort_q | bus.reset_mem_req;
  assign last_beat = (beat_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      line_q      <= '0;
      we_q        <= 1'b0;
      wline_q     <= '0;
      shadow_q    <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
      abort_q     <= 1'b0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.is_mem_req) begin
            line_q      <= bus.mem_addr[19:4];
            we_q        <= bus.mem_we;
            wline_q     <= bus.dcache_to_mem_data_out;
            beat_q      <= 2'd0;
            tmo_q       <= 8'd0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b1;
            ext_req_q   <= 1'b1;
            ext_we_q    <= bus.mem_we;
            ext_addr_q  <= beat_addr(bus.mem_addr[19:4], 2'd0);
            ext_wdata_q <= word_sel(bus.dcache_to_mem_data_out, 2'd0);
            state       <= BEAT;
          end
        end

        BEAT: begin
          if (bus.reset_mem_req) abort_q <= 1'b1;
          if (ack_hit) begin
            if (!we_q && !last_beat) shadow_q <= shadow_put(shadow_q, beat_q, bus.ext_rdata);
            if (abort_now || last_beat) begin
              ext_req_q   <= 1'b0;
              ext_we_q    <= 1'b0;
              ext_addr_q  <= '0;
              ext_wdata_q <= '0;
            end
            if (abort_now) begin
              abort_q <= 1'b0;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end else if (last_beat) begin
              ready_q <= 1'b1;
              if (!we_q) data_q <= {bus.ext_rdata, shadow_q};
              state   <= DONE;
            end else begin
              beat_q      <= beat_q + 2'd1;
              tmo_q       <= 8'd0;
              ext_addr_q  <= beat_addr(line_q, beat_q + 2'd1);
              ext_wdata_q <= word_sel(wline_q, beat_q + 2'd1);
            end
          end else if (tmo_hit) begin
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            tmo_q       <= tmo_next;
            if (abort_now) begin
              abort_q <= 1'b0;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end else begin
              ready_q <= 1'b1;
              error_q <= 1'b1;
              data_q  <= '0;
              state   <= DONE;
            end
          end else begin
            tmo_q <= tmo_next;
          end
        end

        DONE: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_from_mem = data_q;
  assign bus.mem_ready     = ready_q;
  assign bus.mem_error     = error_q;
  assign bus.busy          = busy_q;
  assign bus.ext_req       = ext_req_q;
  assign bus.ext_we        = ext_we_q;
  assign bus.ext_addr      = ext_addr_q;
  assign bus.ext_wdata     = ext_wdata_q;
endmodule
